uart_tx_fifo_param: RTL and testbench

Parametrised successor to the single-word UART transmitter. Serialises words of configurable width, LSB first, with per-word parity and stop-bit options. Adds a programmable bit-period prescaler and an input FIFO that decouples the producer from the line. Sits between the system-side producer and the serial pin, in the same clock domain as the producer.

---
 rtl/uart_tx_fifo_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with configurable word width, per-word parity/stop options,
// programmable bit-period prescaler and an input FIFO in front of the line.
module uart_tx_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         p_data,
    input  logic                          data_valid,
    input  logic                          par_en,
    input  logic                          par_typ,
    input  logic                          stop2,
    input  logic [PRESCALE_W-1:0]         prescale,
    output logic                          ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_WIDTH + 3;
    localparam int unsigned BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr, r_rd;
    logic [AW:0]           r_count;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par_bit, w_par_bit_nxt;
    logic                  r_stop2, w_stop2_nxt;
    logic                  r_stop_idx, w_stop_idx_nxt;
    logic [BW-1:0]         r_bit_idx, w_bit_idx_nxt;
    logic [PRESCALE_W-1:0] r_presc, w_presc_nxt;
    logic [PRESCALE_W-1:0] r_cnt, w_cnt_nxt;
    logic                  r_tx, w_tx_nxt;

    logic                  w_push, w_pop, w_load, w_empty, w_bit_end;
    logic [EW-1:0]         w_head;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign w_empty     = (r_count == '0);
    assign ready       = (r_count != (AW+1)'(FIFO_DEPTH));
    assign w_push      = data_valid && ready;
    assign w_head      = r_mem[r_rd];
    assign w_head_data = w_head[DATA_WIDTH-1:0];
    assign w_bit_end   = (r_cnt == '0);

    assign tx_out      = r_tx;
    assign busy        = (r_state != S_IDLE);
    assign fifo_level  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {stop2, par_typ, par_en, p_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_bit_idx  <= '0;
            r_presc    <= '0;
            r_cnt      <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_stop2    <= w_stop2_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_presc    <= w_presc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_stop2_nxt    = r_stop2;
        w_stop_idx_nxt = r_stop_idx;
        w_bit_idx_nxt  = r_bit_idx;
        w_presc_nxt    = r_presc;
        w_cnt_nxt      = r_cnt;
        w_load         = 1'b0;
        w_pop          = 1'b0;
        w_tx_nxt       = 1'b1;

        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_bit_end ? r_presc : r_cnt - PRESCALE_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_load = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
                        w_state_nxt    = r_par_en ? S_PARITY : S_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt    = S_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_idx) begin
                        w_stop_idx_nxt = 1'b1;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Frame start: fields and the bit period are frozen for the whole frame.
        if (w_load) begin
            w_pop         = 1'b1;
            w_state_nxt   = S_START;
            w_shift_nxt   = w_head_data;
            w_par_en_nxt  = w_head[DATA_WIDTH];
            w_par_bit_nxt = (^w_head_data) ^ w_head[DATA_WIDTH+1];
            w_stop2_nxt   = w_head[DATA_WIDTH+2];
            w_presc_nxt   = prescale;
            w_cnt_nxt     = prescale;
        end

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_bit_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: constant frame vectors, FIFO/reset sequences and
// randomized traffic checked every cycle against a queue-of-line-bits model.
module tb_uart_tx_fifo_param;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid, par_en, par_typ, stop2;
    logic [7:0] prescale;
    logic       ready, tx_out, busy;
    logic [2:0] fifo_level;

    logic [6:0] p7;
    logic       dv7, rdy7, tx7, busy7;
    logic [2:0] lvl7;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.DATA_WIDTH(8), .PRESCALE_W(8), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
        .ready(ready), .tx_out(tx_out), .busy(busy), .fifo_level(fifo_level)
    );

    uart_tx_fifo_param #(.DATA_WIDTH(7), .PRESCALE_W(8), .FIFO_DEPTH(4)) u_dut7 (
        .clk(clk), .rst(rst), .p_data(p7), .data_valid(dv7),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
        .ready(rdy7), .tx_out(tx7), .busy(busy7), .fifo_level(lvl7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of words, plus the remaining line samples of the
    // frame in flight (one entry per clock cycle).
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       s2;
    } mword_t;

    mword_t mq[$];
    bit     ml[$];
    int     m_sz;
    mword_t m_w;
    bit     chk_en = 1'b0;
    logic   exp_tx, exp_busy;
    int     exp_lvl;

    function automatic void build_frame(input mword_t w, input int ps);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w.d[i]);
        if (w.pe) bits.push_back((($countones(w.d) % 2) == 1) ^ w.pt);
        bits.push_back(1'b1);
        if (w.s2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r <= ps; r++) ml.push_back(bits[i]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            ml.delete();
        end else begin
            m_sz = mq.size();
            if (ml.size() != 0) void'(ml.pop_front());
            if (ml.size() == 0 && m_sz != 0) begin
                m_w = mq.pop_front();
                build_frame(m_w, int'(prescale));
            end
            if (data_valid && m_sz < DEPTH)
                mq.push_back('{d: p_data, pe: par_en, pt: par_typ, s2: stop2});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_tx   = (ml.size() != 0) ? ml[0] : 1'b1;
            exp_busy = (ml.size() != 0);
            exp_lvl  = mq.size();
            tests++;
            if (tx_out !== exp_tx || busy !== exp_busy ||
                fifo_level !== 3'(exp_lvl) || ready !== (exp_lvl < DEPTH)) begin
                fails++;
                $display("FAIL model t=%0t tx=%b/%b busy=%b/%b level=%0d/%0d ready=%b/%b (got/expected)",
                         $time, tx_out, exp_tx, busy, exp_busy, fifo_level, exp_lvl,
                         ready, (exp_lvl < DEPTH));
            end
        end
    end

    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic        s2;
        int          ps;
        int          nb;
        logic [11:0] pat;   // line bits in time order, left-aligned
    } vec_t;

    vec_t vec[6];

    initial begin
        int len, bad_tx, bad_busy, idx, acc, word, n;
        logic was_ready;
        logic [9:0] pat7;

        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int len, bad_tx, bad_busy, idx, acc, word, n;
        logic was_ready;
        logic [9:0] pat7;

        vec[0] = '{8'h69, 1'b0, 1'b0, 1'b0, 0, 10, 12'b0100_1011_0100};
        vec[1] = '{8'h96, 1'b1, 1'b0, 1'b0, 0, 11, 12'b0011_0100_1010};
        vec[2] = '{8'h1E, 1'b1, 1'b1, 1'b0, 0, 11, 12'b0011_1100_0110};
        vec[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 0, 12, 12'b0110_0001_1111};
        vec[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 3, 10, 12'b0111_1111_1100};
        vec[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1, 12, 12'b0000_0000_0011};

        rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
        stop2 = 1'b0; prescale = '0; p7 = '0; dv7 = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_out, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 1);
        check("reset_level", fifo_level, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single frames; prescale is changed after the frame has started.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            p_data = vec[v].d; par_en = vec[v].pe; par_typ = vec[v].pt;
            stop2 = vec[v].s2; prescale = 8'(vec[v].ps); data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            len = vec[v].nb * (vec[v].ps + 1);
            bad_tx = 0; bad_busy = 0;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (c == 1) prescale = '0;
                idx = 11 - c / (vec[v].ps + 1);
                if (tx_out !== vec[v].pat[idx]) bad_tx++;
                if (busy !== 1'b1) bad_busy++;
            end
            check($sformatf("frame_tx_bad_cycles_v%0d", v), bad_tx, 0);
            check($sformatf("frame_busy_bad_cycles_v%0d", v), bad_busy, 0);
            @(negedge clk);
            check($sformatf("frame_end_v%0d", v), {tx_out, busy}, 2'b10);
        end

        // 7-bit variant: 7'h55 even parity.
        pat7 = 10'b0101010101;
        @(negedge clk);
        p7 = 7'h55; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = '0; dv7 = 1'b1;
        @(negedge clk);
        dv7 = 1'b0;
        bad_tx = 0; bad_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idx = 9 - c;
            if (tx7 !== pat7[idx]) bad_tx++;
            if (busy7 !== 1'b1) bad_busy++;
        end
        check("w7_frame_tx_bad_cycles", bad_tx, 0);
        check("w7_frame_busy_bad_cycles", bad_busy, 0);
        @(negedge clk);
        check("w7_frame_end", {tx7, busy7}, 2'b10);

        // FIFO full: producer streams words 1,2,3,... with data_valid held high.
        @(negedge clk);
        prescale = 8'd15; par_en = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
        word = 1; acc = 0; p_data = 8'(word);
        for (int c = 0; c < 20; c++) begin
            was_ready = ready;
            @(posedge clk);
            if (was_ready) begin acc++; word++; end
            @(negedge clk);
            p_data = 8'(word);
        end
        data_valid = 1'b0;
        check("full_accepted", acc, 5);
        check("full_ready", ready, 0);
        check("full_level", fifo_level, 4);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("full_drain_busy", busy, 0);
        @(negedge clk);
        check("full_busy_run", last_run, 800);

        // Mid-frame reset during DATA of the 2nd of three queued words.
        prescale = '0;
        p_data = 8'hA5; data_valid = 1'b1;
        @(negedge clk); p_data = 8'h5A;
        @(negedge clk); p_data = 8'h3C;
        @(negedge clk); data_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_level", fifo_level, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_line", {tx_out, busy}, 2'b10);
        check("midreset_level", fifo_level, 0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) n++;
        end
        check("post_reset_quiet_bad_cycles", n, 0);

        // Randomized traffic, prescale varying every cycle, rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 499) == 0);
            data_valid = ($urandom_range(0, 5) == 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            stop2      = 1'($urandom);
            prescale   = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0; data_valid = 1'b0;
        n = 0;
        while ((busy === 1'b1 || fifo_level !== 3'd0) && n < 3000) begin @(negedge clk); n++; end
        check("random_drain", {busy, fifo_level}, 4'b0000);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
